// File: rtl/golomb_len_arbiter.sv
// golomb_len_arbiter: two requesters (0 = DC path, 1 = AC run/level path) share
// one exp-Golomb codeword length unit through a round-robin arbiter.
// Results come back with the requester id after a 2-stage pipeline. The block
// also keeps a per-requester bit total for each slice and runs the
// slice start / drain / done handshake for the slice packer.
module golomb_len_arbiter #(
   parameter int TOTAL_W = 32,
   parameter int SAT_EN  = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               slice_start,
   input  logic               slice_end,
   input  logic               r0_valid,
   output logic               r0_ready,
   input  logic [31:0]        r0_val,
   input  logic [2:0]         r0_k,
   input  logic               r0_setbit,
   input  logic               r1_valid,
   output logic               r1_ready,
   input  logic [31:0]        r1_val,
   input  logic [2:0]         r1_k,
   input  logic               r1_setbit,
   output logic               res_valid,
   output logic               res_id,
   output logic [31:0]        res_len,
   output logic [31:0]        res_sum,
   output logic [TOTAL_W-1:0] total0,
   output logic [TOTAL_W-1:0] total1,
   output logic               slice_done,
   output logic               busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   state_t      state, state_nxt;
   logic        rr_last;              // id granted most recently
   logic        grant0, grant1, accept, acc_id;
   logic [31:0] mux_val;
   logic [2:0]  mux_k;
   logic        mux_setbit;

   // stage 1: tag plus registered sum
   logic        s1_v, s1_id, s1_setbit;
   logic [32:0] s1_sum;
   logic [2:0]  s1_k;
   // stage 2: tag plus registered length and sum
   logic        s2_v, s2_id;
   logic [31:0] s2_len, s2_sum;

   logic [5:0]  s1_msb;
   logic [31:0] cw_len;

   // Bit position of the highest set bit (sum >= 1 whenever it matters).
   function automatic logic [5:0] msb_index(input logic [32:0] x);
      logic [5:0] idx;
      idx = '0;
      for (int i = 0; i < 33; i++) begin
         if (x[i]) idx = 6'(i);
      end
      return idx;
   endfunction

   // Adds a length to a total, clamping or wrapping at TOTAL_W bits.
   function automatic logic [TOTAL_W-1:0] acc_add(input logic [TOTAL_W-1:0] a,
                                                  input logic [31:0] len);
      logic [TOTAL_W:0] s;
      s = {1'b0, a} + {1'b0, TOTAL_W'(len)};
      if ((SAT_EN != 0) && s[TOTAL_W]) return '1;
      return s[TOTAL_W-1:0];
   endfunction

   // Round-robin grant, live only in RUN while no slice_end is pending.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == ST_RUN && !slice_end) begin
         if (r0_valid && r1_valid) begin
            if (rr_last) grant0 = 1'b1;
            else         grant1 = 1'b1;
         end else begin
            grant0 = r0_valid;
            grant1 = r1_valid;
         end
      end
   end

   assign r0_ready = grant0;
   assign r1_ready = grant1;
   assign accept   = grant0 | grant1;
   assign acc_id   = grant1;

   // Operand mux: requester 1 only when granted, otherwise requester 0's fields.
   always_comb begin
      mux_val    = r0_val;
      mux_k      = r0_k;
      mux_setbit = r0_setbit;
      if (grant1) begin
         mux_val    = r1_val;
         mux_k      = r1_k;
         mux_setbit = r1_setbit;
      end
   end

   // Exp-Golomb order-k length: 2*floor(log2(val + 2^k)) + 1 - k, plus 2 for setbit.
   assign s1_msb = msb_index(s1_sum);
   assign cw_len = {25'd0, s1_msb, 1'b0} + 32'd1 - {29'd0, s1_k} + {30'd0, s1_setbit, 1'b0};

   // FSM next state and state-decoded outputs.
   always_comb begin
      state_nxt  = state;
      slice_done = 1'b0;
      busy       = (state != ST_IDLE);
      case (state)
         ST_IDLE:  if (slice_start) state_nxt = ST_RUN;
         ST_RUN:   if (slice_end)   state_nxt = ST_DRAIN;
         ST_DRAIN: if (!s1_v && !s2_v) state_nxt = ST_DONE;
         ST_DONE: begin
            slice_done = 1'b1;
            state_nxt  = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register and round-robin pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset_n) begin
         state   <= ST_IDLE;
         rr_last <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) rr_last <= acc_id;
      end
   end

   // Two-stage pipeline carrying the {valid,id} tag alongside the unit's data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_v      <= 1'b0;
         s1_id     <= 1'b0;
         s1_sum    <= '0;
         s1_k      <= '0;
         s1_setbit <= 1'b0;
         s2_v      <= 1'b0;
         s2_id     <= 1'b0;
         s2_len    <= '0;
         s2_sum    <= '0;
      end else begin
         s1_v      <= accept;
         s1_id     <= acc_id;
         s1_sum    <= {1'b0, mux_val} + (33'd1 << mux_k);
         s1_k      <= mux_k;
         s1_setbit <= mux_setbit;
         s2_v      <= s1_v;
         s2_id     <= s1_id;
         s2_len    <= cw_len;
         s2_sum    <= s1_sum[31:0];
      end
   end

   assign res_valid = s2_v;
   assign res_id    = s2_id;
   assign res_len   = s2_v ? s2_len : 32'd0;
   assign res_sum   = s2_v ? s2_sum : 32'd0;

   // Per-requester totals: cleared by an honoured slice_start, bumped by each result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         total0 <= '0;
         total1 <= '0;
      end else if (state == ST_IDLE && slice_start) begin
         total0 <= '0;
         total1 <= '0;
      end else if (s2_v) begin
         if (s2_id) total1 <= acc_add(total1, s2_len);
         else       total0 <= acc_add(total0, s2_len);
      end
   end

endmodule

// File: tb/tb_golomb_len_arbiter.sv
// Directed bench for golomb_len_arbiter. A 32-bit saturating instance carries
// the main checks; two 4-bit instances (saturating and wrapping) share the
// same stimulus for the total-width boundary cases.
module tb_golomb_len_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        slice_start, slice_end;
   logic        r0_valid, r0_setbit, r1_valid, r1_setbit;
   logic [31:0] r0_val, r1_val;
   logic [2:0]  r0_k, r1_k;

   logic        r0_ready, r1_ready, res_valid, res_id, slice_done, busy;
   logic [31:0] res_len, res_sum, total0, total1;

   logic        sa_r0_ready, sa_r1_ready, sa_res_valid, sa_res_id, sa_slice_done, sa_busy;
   logic [31:0] sa_res_len, sa_res_sum;
   logic [3:0]  sa_total0, sa_total1;

   logic        wr_r0_ready, wr_r1_ready, wr_res_valid, wr_res_id, wr_slice_done, wr_busy;
   logic [31:0] wr_res_len, wr_res_sum;
   logic [3:0]  wr_total0, wr_total1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   golomb_len_arbiter #(.TOTAL_W(32), .SAT_EN(1)) dut (
      .clk(clk), .reset_n(reset_n), .slice_start(slice_start), .slice_end(slice_end),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_val(r0_val), .r0_k(r0_k), .r0_setbit(r0_setbit),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_val(r1_val), .r1_k(r1_k), .r1_setbit(r1_setbit),
      .res_valid(res_valid), .res_id(res_id), .res_len(res_len), .res_sum(res_sum),
      .total0(total0), .total1(total1), .slice_done(slice_done), .busy(busy));

   golomb_len_arbiter #(.TOTAL_W(4), .SAT_EN(1)) dut_sat (
      .clk(clk), .reset_n(reset_n), .slice_start(slice_start), .slice_end(slice_end),
      .r0_valid(r0_valid), .r0_ready(sa_r0_ready), .r0_val(r0_val), .r0_k(r0_k), .r0_setbit(r0_setbit),
      .r1_valid(r1_valid), .r1_ready(sa_r1_ready), .r1_val(r1_val), .r1_k(r1_k), .r1_setbit(r1_setbit),
      .res_valid(sa_res_valid), .res_id(sa_res_id), .res_len(sa_res_len), .res_sum(sa_res_sum),
      .total0(sa_total0), .total1(sa_total1), .slice_done(sa_slice_done), .busy(sa_busy));

   golomb_len_arbiter #(.TOTAL_W(4), .SAT_EN(0)) dut_wrap (
      .clk(clk), .reset_n(reset_n), .slice_start(slice_start), .slice_end(slice_end),
      .r0_valid(r0_valid), .r0_ready(wr_r0_ready), .r0_val(r0_val), .r0_k(r0_k), .r0_setbit(r0_setbit),
      .r1_valid(r1_valid), .r1_ready(wr_r1_ready), .r1_val(r1_val), .r1_k(r1_k), .r1_setbit(r1_setbit),
      .res_valid(wr_res_valid), .res_id(wr_res_id), .res_len(wr_res_len), .res_sum(wr_res_sum),
      .total0(wr_total0), .total1(wr_total1), .slice_done(wr_slice_done), .busy(wr_busy));

   // Counts one comparison and reports it if observed differs from expected.
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      slice_start = 1'b0; slice_end = 1'b0;
      r0_valid = 1'b0; r0_val = '0; r0_k = '0; r0_setbit = 1'b0;
      r1_valid = 1'b0; r1_val = '0; r1_k = '0; r1_setbit = 1'b0;
   endtask

   // Steps until slice_done is seen or the cycle budget runs out.
   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (slice_done === 1'b1) seen = 1'b1;
         else tick();
      end
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
   endtask

   task automatic open_slice();
      slice_start = 1'b1;
      tick();
      slice_start = 1'b0;
   endtask

   task automatic close_slice(input string tag);
      slice_end = 1'b1;
      tick();
      slice_end = 1'b0;
      wait_done(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_inputs();
      reset_n = 1'b0;
      #12;
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_len",   64'(res_len),   64'd0);
      check("rst_total0",    64'(total0),    64'd0);
      check("rst_slice_done", 64'(slice_done), 64'd0);
      check("rst_busy",      64'(busy),      64'd0);
      reset_n = 1'b1;
      tick();

      // Single r0 request: val=5,k=0 -> sum 6, len 5.
      r0_valid = 1'b1;
      #1;
      check("idle_r0_ready", 64'(r0_ready), 64'd0);
      r0_valid = 1'b0;
      tick();
      open_slice();
      check("t1_busy", 64'(busy), 64'd1);
      r0_valid = 1'b1; r0_val = 32'd5; r0_k = 3'd0; r0_setbit = 1'b0;
      #1;
      check("t1_r0_ready", 64'(r0_ready), 64'd1);
      check("t1_r1_ready", 64'(r1_ready), 64'd0);
      tick();
      r0_valid = 1'b0;
      check("t1_lat1_valid", 64'(res_valid), 64'd0);
      tick();
      check("t1_res_valid", 64'(res_valid), 64'd1);
      check("t1_res_id",    64'(res_id),    64'd0);
      check("t1_res_sum",   64'(res_sum),   64'd6);
      check("t1_res_len",   64'(res_len),   64'd5);
      tick();
      check("t1_after_valid", 64'(res_valid), 64'd0);
      check("t1_after_len",   64'(res_len),   64'd0);
      check("t1_total0",      64'(total0),    64'd5);
      close_slice("t1");
      check("t1_done_total0", 64'(total0), 64'd5);
      check("t1_done_total1", 64'(total1), 64'd0);
      check("t1_done_busy",   64'(busy),   64'd1);
      tick();
      check("t1_post_done", 64'(slice_done), 64'd0);
      check("t1_post_busy", 64'(busy),       64'd0);
      check("t1_total_hold", 64'(total0),    64'd5);

      // Two back-to-back r1 requests: {0,2,1} -> len 5 sum 4; {10,1,0} -> len 6 sum 12.
      open_slice();
      check("t2_total0_cleared", 64'(total0), 64'd0);
      r1_valid = 1'b1; r1_val = 32'd0; r1_k = 3'd2; r1_setbit = 1'b1;
      #1;
      check("t2_a_r1_ready", 64'(r1_ready), 64'd1);
      check("t2_a_r0_ready", 64'(r0_ready), 64'd0);
      tick();
      r1_val = 32'd10; r1_k = 3'd1; r1_setbit = 1'b0;
      #1;
      check("t2_b_r1_ready", 64'(r1_ready), 64'd1);
      tick();
      r1_valid = 1'b0;
      check("t2_a_valid", 64'(res_valid), 64'd1);
      check("t2_a_id",    64'(res_id),    64'd1);
      check("t2_a_len",   64'(res_len),   64'd5);
      check("t2_a_sum",   64'(res_sum),   64'd4);
      tick();
      check("t2_b_valid", 64'(res_valid), 64'd1);
      check("t2_b_id",    64'(res_id),    64'd1);
      check("t2_b_len",   64'(res_len),   64'd6);
      check("t2_b_sum",   64'(res_sum),   64'd12);
      tick();
      check("t2_total1", 64'(total1), 64'd11);
      check("t2_total0", 64'(total0), 64'd0);
      close_slice("t2");
      tick();

      // After reset both held valid: grants 1,0,1,0,1,0; slice_end with both valid.
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      tick();
      open_slice();
      r0_valid = 1'b1; r0_val = 32'd5; r0_k = 3'd0; r0_setbit = 1'b0;
      r1_valid = 1'b1; r1_val = 32'd0; r1_k = 3'd2; r1_setbit = 1'b1;
      for (int i = 0; i < 11; i++) begin
         logic exp_id;
         slice_end = (i == 6);
         if (i == 8) begin
            r0_valid = 1'b0;
            r1_valid = 1'b0;
         end
         #1;
         if (i < 6) begin
            check($sformatf("t3_r1_ready_%0d", i), 64'(r1_ready), 64'((i % 2) == 0));
            check($sformatf("t3_r0_ready_%0d", i), 64'(r0_ready), 64'((i % 2) == 1));
         end else if (i < 8) begin
            check($sformatf("t3_r1_ready_%0d", i), 64'(r1_ready), 64'd0);
            check($sformatf("t3_r0_ready_%0d", i), 64'(r0_ready), 64'd0);
         end
         if (i >= 2 && i <= 7) begin
            exp_id = ((i - 2) % 2 == 0);
            check($sformatf("t3_res_valid_%0d", i), 64'(res_valid), 64'd1);
            check($sformatf("t3_res_id_%0d", i),    64'(res_id),    64'(exp_id));
            check($sformatf("t3_res_len_%0d", i),   64'(res_len),   64'd5);
            check($sformatf("t3_res_sum_%0d", i),   64'(res_sum),   exp_id ? 64'd4 : 64'd6);
         end else begin
            check($sformatf("t3_res_valid_%0d", i), 64'(res_valid), 64'd0);
         end
         if (i == 8) begin
            check("t3_drain_done", 64'(slice_done), 64'd0);
            check("t3_drain_busy", 64'(busy),       64'd1);
         end
         if (i == 9) begin
            check("t3_done",        64'(slice_done), 64'd1);
            check("t3_done_total0", 64'(total0),     64'd15);
            check("t3_done_total1", 64'(total1),     64'd15);
         end
         if (i == 10) begin
            check("t3_idle_busy", 64'(busy),       64'd0);
            check("t3_idle_done", 64'(slice_done), 64'd0);
         end
         tick();
      end
      slice_end = 1'b0;

      // Four r0 results of length 5 into 32-bit, 4-bit saturating and 4-bit wrapping totals.
      open_slice();
      r0_valid = 1'b1; r0_val = 32'd5; r0_k = 3'd0; r0_setbit = 1'b0;
      for (int i = 0; i < 7; i++) begin
         int e;
         if (i == 4) r0_valid = 1'b0;
         #1;
         if (i >= 3) begin
            e = 5 * (i - 2);
            check($sformatf("t5_total0_%0d", i),  64'(total0),    64'(e));
            check($sformatf("t5_sat_total0_%0d", i), 64'(sa_total0), 64'(e > 15 ? 15 : e));
            check($sformatf("t5_wrap_total0_%0d", i), 64'(wr_total0), 64'(e % 16));
         end
         tick();
      end
      check("t5_sat_total1", 64'(sa_total1), 64'd0);
      close_slice("t5");
      tick();

      // Asynchronous reset with two results in flight.
      open_slice();
      r0_valid = 1'b1; r0_val = 32'd5; r0_k = 3'd0; r0_setbit = 1'b0;
      tick();
      tick();
      tick();
      r0_valid = 1'b0;
      check("t6_pre_valid",  64'(res_valid), 64'd1);
      check("t6_pre_total0", 64'(total0),    64'd5);
      #1;
      reset_n = 1'b0;
      #1;
      check("t6_rst_valid",  64'(res_valid), 64'd0);
      check("t6_rst_len",    64'(res_len),   64'd0);
      check("t6_rst_total0", 64'(total0),    64'd0);
      check("t6_rst_total1", 64'(total1),    64'd0);
      check("t6_rst_busy",   64'(busy),      64'd0);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("t6_stale_valid_%0d", i), 64'(res_valid), 64'd0);
         check($sformatf("t6_stale_busy_%0d", i),  64'(busy),      64'd0);
         check($sformatf("t6_stale_total0_%0d", i), 64'(total0),   64'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
